// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, ALU and
// condition codes, and datapath mux select values.
package arm_ctrl_pkg;

    localparam int unsigned STATE_W = 4;
    localparam int unsigned NZCV_W  = 4;

    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    localparam logic       ADR_PC     = 1'b0;
    localparam logic       ADR_ALUOUT = 1'b1;
    localparam logic [1:0] SRCA_REG   = 2'b00;
    localparam logic [1:0] SRCA_PC    = 2'b01;
    localparam logic [1:0] SRCB_WDATA = 2'b00;
    localparam logic [1:0] SRCB_IMM   = 2'b01;
    localparam logic [1:0] SRCB_FOUR  = 2'b10;
    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [3:0] REG_PC = 4'd15;

endpackage

// File: rtl/cond_check.sv
// Evaluates an ARM condition field against the stored NZCV flags.
module cond_check
    import arm_ctrl_pkg::*;
(
    input  logic [3:0] Cond,
    input  logic [3:0] NZCV,
    output logic       CondEx
);

    logic n, z, c, v;
    assign {n, z, c, v} = NZCV;

    always_comb begin
        CondEx = 1'b0;
        case (Cond)
            COND_EQ: CondEx = z;
            COND_NE: CondEx = ~z;
            COND_CS: CondEx = c;
            COND_CC: CondEx = ~c;
            COND_MI: CondEx = n;
            COND_PL: CondEx = ~n;
            COND_VS: CondEx = v;
            COND_VC: CondEx = ~v;
            COND_HI: CondEx = c & ~z;
            COND_LS: CondEx = ~c | z;
            COND_GE: CondEx = (n == v);
            COND_LT: CondEx = (n != v);
            COND_GT: CondEx = ~z & (n == v);
            COND_LE: CondEx = z | (n != v);
            COND_AL: CondEx = 1'b1;
            COND_NV: CondEx = 1'b0;
        endcase
    end

endmodule

// File: rtl/multicycle_control_unit.sv
// Moore sequencer for the multicycle ARM datapath; owns the NZCV flags and
// gates architectural writes of instructions whose condition fails.
module multicycle_control_unit
    import arm_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RST_N,
    input  logic [3:0] Cond,
    input  logic [1:0] Op,
    input  logic [5:0] Funct,
    input  logic [3:0] Rd,
    input  logic [3:0] ALUFlags,
    output logic       PCWrite,
    output logic       IRWrite,
    output logic       MemWrite,
    output logic       RegWrite,
    output logic       AdrSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUControl,
    output logic [1:0] ImmSrc,
    output logic [1:0] RegSrc,
    output logic [3:0] State
);

    state_t            state_q, state_d;
    logic [NZCV_W-1:0] flags_q, flags_d;
    logic              cond_ex_q, cond_ex_d;
    logic              cond_ex_c;
    logic [1:0]        alu_ctrl_c, flag_w_c;
    logic              no_write_c, wb_en_c, wb_pc_c, wb_reg_c;
    logic              pc_write_c, ir_write_c, mem_write_c, reg_write_c;

    cond_check u_cond_check (
        .Cond   (Cond),
        .NZCV   (flags_q),
        .CondEx (cond_ex_c)
    );

    // Data-processing command decode: ALU op, flag-write mask, writeback suppression.
    always_comb begin
        alu_ctrl_c = ALU_ADD;
        flag_w_c   = 2'b00;
        no_write_c = 1'b0;
        case (Funct[4:1])
            CMD_ADD: begin alu_ctrl_c = ALU_ADD; flag_w_c = {Funct[0], Funct[0]}; end
            CMD_SUB: begin alu_ctrl_c = ALU_SUB; flag_w_c = {Funct[0], Funct[0]}; end
            CMD_AND: begin alu_ctrl_c = ALU_AND; flag_w_c = {Funct[0], 1'b0}; end
            CMD_ORR: begin alu_ctrl_c = ALU_ORR; flag_w_c = {Funct[0], 1'b0}; end
            CMD_CMP: begin alu_ctrl_c = ALU_SUB; flag_w_c = 2'b11; no_write_c = 1'b1; end
            default: no_write_c = 1'b1;
        endcase
    end

    assign wb_en_c  = cond_ex_q & ~((Op == 2'b00) & no_write_c);
    assign wb_pc_c  = wb_en_c & (Rd == REG_PC);
    assign wb_reg_c = wb_en_c & (Rd != REG_PC);

    // Flags are captured as the execute state retires; CondEx latched in DECODE.
    always_comb begin
        flags_d   = flags_q;
        cond_ex_d = cond_ex_q;
        if (state_q == S_DECODE) cond_ex_d = cond_ex_c;
        if ((state_q == S_EXECR || state_q == S_EXECI) && cond_ex_q) begin
            if (flag_w_c[1]) flags_d[3:2] = ALUFlags[3:2];
            if (flag_w_c[0]) flags_d[1:0] = ALUFlags[1:0];
        end
    end

    always_comb begin
        state_d     = state_q;
        pc_write_c  = 1'b0;
        ir_write_c  = 1'b0;
        mem_write_c = 1'b0;
        reg_write_c = 1'b0;
        AdrSrc      = ADR_PC;
        ALUSrcA     = SRCA_REG;
        ALUSrcB     = SRCB_WDATA;
        ResultSrc   = RES_ALUOUT;
        ALUControl  = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write_c = 1'b1;
                pc_write_c = 1'b1;
                ALUSrcA    = SRCA_PC;
                ALUSrcB    = SRCB_FOUR;
                ResultSrc  = RES_ALURES;
                state_d    = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_PC;
                ALUSrcB = SRCB_FOUR;
                case (Op)
                    2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
                    2'b01:   state_d = S_MEMADR;
                    2'b10:   state_d = S_BRANCH;
                    default: state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcB = SRCB_IMM;
                state_d = Funct[0] ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc  = ADR_ALUOUT;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc   = RES_DATA;
                pc_write_c  = wb_pc_c;
                reg_write_c = wb_reg_c;
                state_d     = S_FETCH;
            end
            S_MEMWR: begin
                AdrSrc      = ADR_ALUOUT;
                mem_write_c = cond_ex_q;
                state_d     = S_FETCH;
            end
            S_EXECR: begin
                ALUControl = alu_ctrl_c;
                state_d    = S_ALUWB;
            end
            S_EXECI: begin
                ALUSrcB    = SRCB_IMM;
                ALUControl = alu_ctrl_c;
                state_d    = S_ALUWB;
            end
            S_ALUWB: begin
                pc_write_c  = wb_pc_c;
                reg_write_c = wb_reg_c;
                state_d     = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcB    = SRCB_IMM;
                ResultSrc  = RES_ALURES;
                pc_write_c = cond_ex_q;
                state_d    = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q   <= S_FETCH;
            flags_q   <= '0;
            cond_ex_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            flags_q   <= flags_d;
            cond_ex_q <= cond_ex_d;
        end
    end

    // Reset kills write enables immediately, even mid-instruction.
    assign PCWrite  = pc_write_c  & RST_N;
    assign IRWrite  = ir_write_c  & RST_N;
    assign MemWrite = mem_write_c & RST_N;
    assign RegWrite = reg_write_c & RST_N;

    assign ImmSrc = (Op == 2'b11) ? 2'b00 : Op;
    assign RegSrc = (Op == 2'b10) ? 2'b01 :
                    ((Op == 2'b01) && !Funct[0]) ? 2'b10 : 2'b00;
    assign State  = 4'(state_q);

endmodule

// File: doc/multicycle_control_unit.md
# multicycle_control_unit

Sequencing controller for the multicycle ARM datapath: a Moore FSM that steps each instruction through fetch, decode, execute, memory and writeback. It drives every mux select and write enable of the shared datapath, which has one memory port, one ALU, and the IR, Data, A, WriteData and ALUOut registers. It owns the NZCV flag register and evaluates the condition field once per instruction, gating all architectural writes of failed instructions.

## Interface
- No parameters.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- Cond  in  4  Instr[31:28].
- Op  in  2  Instr[27:26]: 00 data-processing, 01 memory, 10 branch, 11 unsupported.
- Funct  in  6  Instr[25:20].
  - Data-processing: [5]=I, [4:1]=cmd, [0]=S.
  - Memory: [0]=L.
- Rd  in  4  Instr[15:12].
- ALUFlags  in  4  {N,Z,C,V} from the ALU, valid in the execute states.
- PCWrite  out  1  PC register enable.
- IRWrite  out  1  IR enable.
- MemWrite  out  1  memory write enable.
- RegWrite  out  1  register-file write enable.
- AdrSrc  out  1  memory address select: 0=PC, 1=ALUOut.
- ALUSrcA  out  2  00=A, 01=PC.
- ALUSrcB  out  2  00=WriteData, 01=ExtImm, 10=constant 4.
- ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult.
- ALUControl  out  2  00 ADD, 01 SUB, 10 AND, 11 ORR.
- ImmSrc  out  2  Op-driven immediate extend select.
- RegSrc  out  2  [0]=1 reads R15 as Rn (branch); [1]=1 reads Rd as Rm (STR).
- State  out  4  current state, for debug.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH.
- FETCH:
  - Outputs: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ALUControl=ADD, ResultSrc=10, PCWrite=1.
  - Next state: DECODE.
- DECODE:
  - Outputs: ALUSrcA=01, ALUSrcB=10, ALUControl=ADD. This forms PC+8 for the R15 read.
  - Registers CondEx, the cond_check result computed from Cond and the current flags.
  - Next state by Op:
    - 01 → MEMADR.
    - 00 with Funct[5]=1 → EXECI.
    - 00 with Funct[5]=0 → EXECR.
    - 10 → BRANCH.
    - 11 → FETCH.
- MEMADR: ALUSrcA=00, ALUSrcB=01, ADD. Next state MEMRD if L=1, MEMWR if L=0.
- MEMRD: AdrSrc=1. Next state MEMWB.
- MEMWB: ResultSrc=01. Next state FETCH.
- MEMWR: AdrSrc=1, MemWrite=CondEx. Next state FETCH.
- EXECR uses ALUSrcB=00; EXECI uses ALUSrcB=01. Both use ALUSrcA=00 and next state ALUWB.
- ALUWB: ResultSrc=00. Next state FETCH.
- BRANCH: ALUSrcA=00, ALUSrcB=01, ADD, ResultSrc=10, PCWrite=CondEx. Next state FETCH.
- Command decode:
  - ADD 0100 → ADD.
  - SUB 0010 → SUB.
  - AND 0000 → AND.
  - ORR 1100 → ORR.
  - CMP 1010 → SUB, no register write, S forced 1.
  - Any other cmd → ADD, no register or flag write (NOP).
- Flag write (FlagW):
  - S=1 on ADD/SUB/CMP → FlagW=11 (NZ and CV).
  - S=1 on AND/ORR → FlagW=10 (NZ only).
  - The flag register loads on the clock edge that leaves EXECR/EXECI, only when CondEx=1.
- Writeback in MEMWB and ALUWB:
  - Rd≠15: RegWrite=CondEx, PCWrite=0.
  - Rd=15: RegWrite=0, PCWrite=CondEx.
  - CMP and NOP commands: both RegWrite and PCWrite are 0.
- Condition codes (cond_check):
  - 0000 EQ (Z), 0001 NE, 0010 CS (C), 0011 CC, 0100 MI (N), 0101 PL, 0110 VS (V), 0111 VC.
  - 1000 HI (C&~Z), 1001 LS, 1010 GE (N==V), 1011 LT, 1100 GT (~Z&N==V), 1101 LE.
  - 1110 AL (always true); 1111 reserved, evaluates false.
- ImmSrc by Op: 00→00 (imm8), 01→01 (imm12), 10→10 (imm24).
- RegSrc by Op: 10→01, memory store (Op=01, L=0)→10, otherwise 00.

## Timing
- Reset (RST_N low):
  - State=FETCH, flags=0000, CondEx=0.
  - PCWrite, IRWrite, MemWrite and RegWrite are forced to 0 combinationally by RST_N.
  - The first fetch completes on the first rising edge after release.
- Reset asserted mid-instruction aborts the instruction; no write enable pulses after assertion.
- Cycles per instruction (FETCH included): B=3, data-processing=4, STR=4, LDR=5, unsupported=2.
- Conditional failure does not shorten the instruction; the state path is unchanged.
- All control outputs are Moore outputs of the current state; none of them depends combinationally on ALUFlags.
- Flags written by instruction N are visible to the CondEx of instruction N+1, because DECODE follows the flag write.

## Structure
- Package arm_ctrl_pkg holds:
  - the state enum;
  - ALUControl codes;
  - the 16 condition codes;
  - AdrSrc, ALUSrcA, ALUSrcB and ResultSrc select constants.
- Sub-module cond_check: combinational, inputs Cond and NZCV, output CondEx.
- The FSM, the command decode and the flag register live in multicycle_control_unit.

## Test plan
- Reset then ADD R1,R2,R3 (Op=00, Funct=001000, Cond=1110) → states FETCH, DECODE, EXECR, ALUWB; RegWrite=1 only in ALUWB; the next FETCH falls on cycle 5.
- CMP with S, ALUFlags=0100 → flags=0100; then BEQ (Cond=0000, Op=10) → PCWrite=1 in BRANCH. BNE instead → PCWrite=0 in BRANCH, still 3 cycles.
- LDR to Rd=15 (Op=01, Funct[0]=1) → 5 cycles; MEMWB has PCWrite=1, RegWrite=0, ResultSrc=01.
- STR with Cond=0001 while Z=1 → MEMWR has MemWrite=0; RegSrc=10 throughout.
- ANDS with ALUFlags=1011, prior flags=0000 → flags=1000 (C and V unchanged).
- RST_N asserted in MEMWR → MemWrite drops immediately; after release State=FETCH and flags=0000.
